// File: rtl/anf_mono_pkg.sv
// ============================================================================
//  Module   : anf_mono_pkg
//  Purpose  : Shared constants and elaboration-time helpers for the ANF
//             monomial expander pipeline (binomials, bit offsets, ranks).
//  Options  : ANF_MONO_CONST_TERM_EN adds a constant-1 monomial at bit 0.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package anf_mono_pkg;

`ifdef ANF_MONO_CONST_TERM_EN
  localparam int CONST_OFS = 1;
`else
  localparam int CONST_OFS = 0;
`endif

  // C(n,k); each partial product is itself a binomial, so division is exact
  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    if (k < 0 || k > n) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // First output bit index holding a monomial of degree k
  function automatic int mono_offset(input int n, input int k);
    int o;
    o = CONST_OFS;
    for (int j = 1; j < k; j++) o += binom(n, j);
    return o;
  endfunction

  // Total output width for degrees 1..d (plus the optional constant term)
  function automatic int num_mono(input int n, input int d);
    return mono_offset(n, d + 1);
  endfunction

  // Width of the runtime degree-limit field
  function automatic int deg_width(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

  function automatic int popcount(input int x, input int n);
    int c;
    c = 0;
    for (int v = 0; v < n; v++) c += (x >> v) & 1;
    return c;
  endfunction

  // Lexicographic order of sorted index tuples of equal size: the tuple that
  // owns the first differing variable has the smaller element there.
  function automatic bit tuple_less(input int a, input int b, input int n);
    for (int v = 0; v < n; v++) begin
      if (((a >> v) & 1) != ((b >> v) & 1)) return ((a >> v) & 1) == 1;
    end
    return 1'b0;
  endfunction

  // Position of mask m among all masks of the same degree
  function automatic int mono_rank(input int n, input int m);
    int r;
    r = 0;
    for (int x = 1; x < (1 << n); x++) begin
      if (popcount(x, n) == popcount(m, n) && tuple_less(x, m, n)) r++;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/anf_monomial_pipe_if.sv
// ============================================================================
//  Module   : anf_monomial_pipe_if
//  Purpose  : Input/output valid-ready bundle of the monomial pipeline.
//             master = producer/consumer side, slave = pipeline side.
//  Options  : ANF_MONO_CONST_TERM_EN widens out_mono by one bit.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

interface anf_monomial_pipe_if #(
  parameter int N_IN    = 4,
  parameter int MAX_DEG = 4
);
  import anf_mono_pkg::*;

  localparam int NUM_MONO = num_mono(N_IN, MAX_DEG);
  localparam int DEG_W    = deg_width(MAX_DEG);

  logic                in_valid;
  logic                in_ready;
  logic [N_IN-1:0]     in_data;
  logic [DEG_W-1:0]    in_deg;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_MONO-1:0] out_mono;

  modport master (
    output in_valid, in_data, in_deg, out_ready,
    input  in_ready, out_valid, out_mono
  );

  modport slave (
    input  in_valid, in_data, in_deg, out_ready,
    output in_ready, out_valid, out_mono
  );
endinterface

`default_nettype wire

// File: rtl/anf_mono_gen.sv
// ============================================================================
//  Module   : anf_mono_gen
//  Purpose  : Combinational expander: variable vector -> every AND-monomial of
//             degree 1..MAX_DEG, degree-major, lexicographic within a degree.
//             Monomials above the runtime degree limit are forced to 0.
//  Options  : ANF_MONO_CONST_TERM_EN drives a constant 1 on mono[0].
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module anf_mono_gen
  import anf_mono_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int MAX_DEG = 4,
  localparam int NUM_MONO = num_mono(N_IN, MAX_DEG),
  localparam int DEG_W    = deg_width(MAX_DEG)
) (
  input  wire logic [N_IN-1:0]     data,
  input  wire logic [DEG_W-1:0]    deg,
  output      logic [NUM_MONO-1:0] mono
);

  // Variable i is data[N_IN-1-i]; vars[i] holds variable i directly
  logic [N_IN-1:0] w_vars;

  for (genvar i = 0; i < N_IN; i++) begin : g_var
    assign w_vars[i] = data[N_IN-1-i];
  end

`ifdef ANF_MONO_CONST_TERM_EN
  assign mono[0] = 1'b1;
`endif

  // One AND term per variable subset; its bit slot follows from degree + rank
  for (genvar k = 1; k <= MAX_DEG; k++) begin : g_deg
    localparam logic [DEG_W-1:0] c_k = DEG_W'(k);
    for (genvar m = 1; m < (1 << N_IN); m++) begin : g_mask
      if (popcount(m, N_IN) == k) begin : g_term
        localparam int              c_bit  = mono_offset(N_IN, k) + mono_rank(N_IN, m);
        localparam logic [N_IN-1:0] c_mask = N_IN'(m);
        assign mono[c_bit] = (deg >= c_k) & (&(w_vars | ~c_mask));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/anf_monomial_pipe.sv
// ============================================================================
//  Module   : anf_monomial_pipe
//  Purpose  : Two-stage valid/ready pipeline around anf_mono_gen. Stage A
//             captures (in_data, in_deg); stage B captures the monomials.
//             in_ready depends combinationally on out_ready (no skid buffer).
//  Options  : ANF_MONO_CONST_TERM_EN adds a constant-1 monomial at bit 0.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module anf_monomial_pipe
  import anf_mono_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int MAX_DEG = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  anf_monomial_pipe_if.slave bus
);

  localparam int NUM_MONO = num_mono(N_IN, MAX_DEG);
  localparam int DEG_W    = deg_width(MAX_DEG);

  logic                r_a_valid;
  logic [N_IN-1:0]     r_a_data;
  logic [DEG_W-1:0]    r_a_deg;
  logic                r_b_valid;
  logic [NUM_MONO-1:0] r_b_mono;
  logic [NUM_MONO-1:0] w_mono;
  logic                w_a_ready;
  logic                w_in_fire;
  logic                w_a_fire;

  assign w_a_ready    = !r_b_valid || bus.out_ready;
  assign bus.in_ready = !r_a_valid || w_a_ready;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_a_fire     = r_a_valid && w_a_ready;

  assign bus.out_valid = r_b_valid;
  assign bus.out_mono  = r_b_mono;

  anf_mono_gen #(
    .N_IN    (N_IN),
    .MAX_DEG (MAX_DEG)
  ) u_gen (
    .data (r_a_data),
    .deg  (r_a_deg),
    .mono (w_mono)
  );

  // Stage A: capture accepted input; a new fill wins over a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
      r_a_deg   <= '0;
    end else if (w_in_fire) begin
      r_a_valid <= 1'b1;
      r_a_data  <= bus.in_data;
      r_a_deg   <= bus.in_deg;
    end else if (w_a_fire) begin
      r_a_valid <= 1'b0;
    end
  end

  // Stage B: capture expanded monomials; hold them while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_mono  <= '0;
    end else if (w_a_fire) begin
      r_b_valid <= 1'b1;
      r_b_mono  <= w_mono;
    end else if (bus.out_ready) begin
      r_b_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_anf_monomial_pipe.sv
// ============================================================================
//  Module   : tb_anf_monomial_pipe
//  Purpose  : Directed self-checking bench for anf_monomial_pipe (4/4 and
//             6/3 configurations) with hand-computed expected vectors.
//  Options  : ANF_MONO_CONST_TERM_EN shifts expectations and sets bit 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anf_monomial_pipe;

`ifdef ANF_MONO_CONST_TERM_EN
  localparam int CT = 1;
`else
  localparam int CT = 0;
`endif
  localparam int NM4 = 15 + CT;
  localparam int NM6 = 41 + CT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  anf_monomial_pipe_if #(.N_IN(4), .MAX_DEG(4)) bus4 ();
  anf_monomial_pipe_if #(.N_IN(6), .MAX_DEG(3)) bus6 ();

  anf_monomial_pipe #(.N_IN(4), .MAX_DEG(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  anf_monomial_pipe #(.N_IN(6), .MAX_DEG(3)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6.slave)
  );

  // Stream vectors with hand-derived 15-bit results (no constant term)
  logic [3:0]  vd [6] = '{4'b1100, 4'b0111, 4'b1111, 4'b1011, 4'b0001, 4'b1101};
  logic [2:0]  vg [6] = '{3'd4,    3'd4,    3'd2,    3'd3,    3'd4,    3'd4};
  logic [14:0] ve [6] = '{15'h0013, 15'h238E, 15'h03FF, 15'h126D, 15'h0008, 15'h095B};

  function automatic logic [NM4-1:0] adj4(input logic [14:0] e);
`ifdef ANF_MONO_CONST_TERM_EN
    return {e, 1'b1};
`else
    return e;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transaction with out_ready high; returns what appears 2 clocks later
  task automatic send_one(input logic [3:0] d, input logic [2:0] g,
                          output logic v, output logic [NM4-1:0] m);
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = d;
    bus4.in_deg    = g;
    tick();
    bus4.in_valid  = 1'b0;
    bus4.in_data   = 4'b0110;
    bus4.in_deg    = 3'd1;
    tick();
    v = bus4.out_valid;
    m = bus4.out_mono;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (bus4.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus4.out_valid);
    end
    n_vec++;
    if (bus4.out_mono !== '0) begin
      n_err++; $display("FAIL reset_out_mono: got %h expected 0", bus4.out_mono);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (bus4.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus4.in_ready);
    end
  endtask

  task automatic test_all_ones();
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 4'b1111;
    bus4.in_deg    = 3'd4;
    tick();
    bus4.in_valid  = 1'b0;
    n_vec++;
    if (bus4.out_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_early: out_valid got %b expected 0 after 1 clock", bus4.out_valid);
    end
    tick();
    n_vec++;
    if (bus4.out_valid !== 1'b1 || bus4.out_mono !== adj4(15'h7FFF)) begin
      n_err++; $display("FAIL all_ones: valid %b mono %h expected valid 1 mono %h",
                        bus4.out_valid, bus4.out_mono, adj4(15'h7FFF));
    end
    tick();
    n_vec++;
    if (bus4.out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_cycle_valid: got %b expected 0", bus4.out_valid);
    end
  endtask

  task automatic test_sparse();
    logic v;
    logic [NM4-1:0] m;
    send_one(4'b1010, 3'd4, v, m);
    n_vec++;
    if (v !== 1'b1 || m !== adj4(15'h0025)) begin
      n_err++; $display("FAIL sparse_1010: valid %b mono %h expected valid 1 mono %h", v, m, adj4(15'h0025));
    end
  endtask

  task automatic test_deg_limit();
    logic [2:0]  dg [3] = '{3'd1, 3'd0, 3'd7};
    logic [14:0] ex [3] = '{15'h000F, 15'h0000, 15'h7FFF};
    logic v;
    logic [NM4-1:0] m;
    for (int i = 0; i < 3; i++) begin
      send_one(4'b1111, dg[i], v, m);
      n_vec++;
      if (v !== 1'b1 || m !== adj4(ex[i])) begin
        n_err++; $display("FAIL deg_limit_%0d: valid %b mono %h expected valid 1 mono %h",
                          dg[i], v, m, adj4(ex[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic stalled_prev = 1'b0;
    logic saw_block = 1'b0;
    logic extra = 1'b0;
    logic [NM4-1:0] held = '0;
    while (recv < 6 && cyc < 60) begin
      bus4.out_ready = !(cyc >= 2 && cyc < 7);
      bus4.in_valid  = (sent < 6);
      if (sent < 6) begin
        bus4.in_data = vd[sent];
        bus4.in_deg  = vg[sent];
      end
      @(negedge clk);
      if (stalled_prev) begin
        n_vec++;
        if (bus4.out_valid !== 1'b1 || bus4.out_mono !== held) begin
          n_err++; $display("FAIL stall_stable cyc %0d: valid %b mono %h expected valid 1 mono %h",
                            cyc, bus4.out_valid, bus4.out_mono, held);
        end
      end
      if (bus4.in_valid && !bus4.in_ready) saw_block = 1'b1;
      if (bus4.out_valid && bus4.out_ready) begin
        n_vec++;
        if (recv >= 6) begin
          n_err++; $display("FAIL b2b_extra: unexpected output %h", bus4.out_mono);
        end else if (bus4.out_mono !== adj4(ve[recv])) begin
          n_err++; $display("FAIL b2b_out_%0d: got %h expected %h", recv, bus4.out_mono, adj4(ve[recv]));
        end
        recv++;
      end
      stalled_prev = bus4.out_valid && !bus4.out_ready;
      held = bus4.out_mono;
      if (bus4.in_valid && bus4.in_ready) sent++;
      tick();
      cyc++;
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    n_vec++;
    if (recv != 6) begin
      n_err++; $display("FAIL b2b_count: received %0d expected 6", recv);
    end
    n_vec++;
    if (saw_block !== 1'b1) begin
      n_err++; $display("FAIL b2b_backpressure: in_ready low seen %b expected 1", saw_block);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus4.out_valid) extra = 1'b1;
    end
    tick();
    n_vec++;
    if (extra !== 1'b0) begin
      n_err++; $display("FAIL b2b_duplicate: trailing out_valid %b expected 0", extra);
    end
  endtask

  task automatic test_async_reset();
    logic stale = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 4'b1111;
    bus4.in_deg    = 3'd4;
    tick();
    bus4.in_data   = 4'b1100;
    tick();
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    n_vec++;
    if (bus4.out_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_inflight: out_valid got %b expected 1", bus4.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus4.out_valid !== 1'b0 || bus4.out_mono !== '0) begin
      n_err++; $display("FAIL arst_immediate: valid %b mono %h expected valid 0 mono 0",
                        bus4.out_valid, bus4.out_mono);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus4.out_valid !== 1'b0) stale = 1'b1;
    end
    n_vec++;
    if (stale !== 1'b0) begin
      n_err++; $display("FAIL arst_stale: out_valid seen %b expected 0", stale);
    end
    n_vec++;
    if (bus4.in_ready !== 1'b1) begin
      n_err++; $display("FAIL arst_in_ready: got %b expected 1", bus4.in_ready);
    end
  endtask

  task automatic test_wide();
    logic [1:0]     dg [3] = '{2'd3, 2'd1, 2'd0};
    logic [NM6-1:0] e;
    bus6.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = '0;
      if (i == 0) e = '1;
      if (i == 1) e[CT +: 6] = 6'h3F;
      e[0] = e[0] | (CT == 1);
      bus6.in_valid = 1'b1;
      bus6.in_data  = 6'h3F;
      bus6.in_deg   = dg[i];
      tick();
      bus6.in_valid = 1'b0;
      tick();
      n_vec++;
      if (bus6.out_valid !== 1'b1 || bus6.out_mono !== e) begin
        n_err++; $display("FAIL wide_deg%0d: valid %b mono %h expected valid 1 mono %h",
                          dg[i], bus6.out_valid, bus6.out_mono, e);
      end
      tick();
    end
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_deg = '0; bus4.out_ready = 1'b0;
    bus6.in_valid = 1'b0; bus6.in_data = '0; bus6.in_deg = '0; bus6.out_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_sparse();
    test_deg_limit();
    test_back_to_back();
    test_async_reset();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
